qnigma_dns_rx: RTL and testbench
================================

Name: qnigma_dns_rx

Overview:
- Byte-stream decoder for DNS responses returned to the DNS client's queries.
- Sits between the UDP receive path and the DNS client: consumes UDP payload bytes of frames addressed to the DNS local port.
- Validates the header, skips the question section, walks the answer records and extracts the first AAAA/IN address.
- Produces one result pulse per frame: valid address or error.

Parameters:
- EXP_TID, 16'd12345, transaction ID that must match the query's TID.
- MAX_NAME, 255, maximum encoded name length in bytes before abort.
- MAX_ANS, 8, maximum answer records walked per frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- dat  in  8  UDP payload byte
- vld  in  1  dat valid this cycle
- sof  in  1  first payload byte of frame (qualified by vld)
- eof  in  1  last payload byte of frame (qualified by vld)
- val  out  1  one-cycle pulse: AAAA address decoded
- err  out  1  one-cycle pulse: frame rejected
- addr  out  128  ip_t, decoded address; held until next val
- tid  out  16  TID of last completed frame
- rcode  out  4  RCODE of last completed frame
- busy  out  1  high from accepted sof until the result pulse

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; val, err and busy 0; addr, tid and rcode all zero.
- Only bytes with vld=1 are consumed. A vld=1 sof=1 byte in any state restarts parsing at header byte 0; an in-flight frame is discarded silently, with no err.
- States:
  - IDLE: wait for sof.
  - HDR: 12 bytes, big-endian TID, FLG, QD, AN, NS, AR.
  - QNAME: skip the question name.
  - QINFO: 4 bytes.
  - ANAME: skip the answer name.
  - AINFO: 10 bytes TYPE, CLASS, TTL, RDLEN.
  - RDATA: RDLEN bytes.
  - DRAIN: ignore bytes until eof.
- Header checks, evaluated after byte 11, failure marks the frame bad:
  - TID == EXP_TID
  - FLG[15] (QR) = 1
  - FLG[3:0] (RCODE) = 0
  - QD == 1
  - AN != 0
- A bad frame goes to DRAIN; err is asserted at eof.
- Name skipping (QNAME and ANAME):
  - Length byte 0x00 ends the name.
  - Top bits 11 mark a compression pointer: consume one more byte, and the name ends.
  - Length 1..63: skip that many bytes.
  - Top bits 01 or 10: bad frame.
  - More than MAX_NAME name bytes: bad frame.
- Pointers are not followed; the name is only skipped.
- Answer matching:
  - TYPE==28, CLASS==1 and RDLEN==16: the 16 RDATA bytes shift into addr_tmp MSB-first and the record is marked found.
  - Otherwise RDATA is skipped with the RDLEN counter. RDLEN 0 proceeds directly to the next ANAME.
- After each record:
  - found: go to DRAIN.
  - Answer count reaches min(AN, MAX_ANS): go to DRAIN.
  - Otherwise: go to ANAME.
- Result timing:
  - On the eof byte, a good frame with found set pulses val on the next cycle, with addr <= addr_tmp and tid/rcode updated.
  - Otherwise err pulses on the next cycle, with tid/rcode updated when the header completed.
  - Latency is 1 cycle from eof to the result pulse. val and err are never both high.
- Truncation: eof arriving in any state other than DRAIN, or with a partial RDATA, produces err, even if addr_tmp was partially filled.
- sof and eof on the same byte (1-byte frame) produces err.
- Only the first matching AAAA is reported; later answers and the NS/AR sections are ignored.
- Counters:
  - Byte and RDLEN counters are 16 bit; RDLEN up to 65535 is honoured without wrap.
  - Answer counter width is $clog2(MAX_ANS+1).
- busy rises on the cycle after an accepted sof and falls together with the val or err pulse.
- Reset mid-frame aborts the frame with no pulse.

Test Plan:
- Valid response, TID 12345, FLG 0x8180, QD=1, AN=1, QNAME "qnigma.io", answer pointer 0xC00C, TYPE 28, CLASS 1, RDLEN 16, address 2001:db8::1 -> val pulse 1 cycle after eof; addr=20010db8000000000000000000000001; err never high.
- Two answers, CNAME (TYPE 5, RDLEN 9) then AAAA fe80::2 -> CNAME skipped; val with addr=fe80::2.
- TID 12346 or RCODE 3 (NXDOMAIN, FLG 0x8183) -> err pulse after eof; rcode=3; addr unchanged from previous value.
- Frame truncated after 8 of 16 RDATA bytes (eof) -> err; val not asserted; addr unchanged.
- sof reasserted mid-QNAME followed by a complete valid frame -> single val for the second frame, no err.
- AN=1 with TYPE 1 (A record, RDLEN 4) only -> err at eof. Label byte 0x80 in QNAME -> DRAIN, then err. Bytes with vld=0 interleaved every other cycle -> same results as the back-to-back case.

Source files
------------

// File: rtl/qnigma_dns_rx_if.sv
// Stream port of the DNS response decoder: UDP payload bytes in, decoded AAAA result out.
interface qnigma_dns_rx_if;
    logic [7:0]   dat;
    logic         vld;
    logic         sof;
    logic         eof;
    logic         val;
    logic         err;
    logic [127:0] addr;
    logic [15:0]  tid;
    logic [3:0]   rcode;
    logic         busy;

    modport master (output dat, vld, sof, eof, input val, err, addr, tid, rcode, busy);
    modport slave  (input dat, vld, sof, eof, output val, err, addr, tid, rcode, busy);
endinterface

// File: rtl/qnigma_dns_rx.sv
// DNS response decoder: checks the header, skips the question, walks answers and
// reports the first AAAA/IN address (or an error) one cycle after the last byte.
module qnigma_dns_rx #(
    parameter logic [15:0] EXP_TID  = 16'd12345,
    parameter int          MAX_NAME = 255,
    parameter int          MAX_ANS  = 8
) (
    input logic            clk,
    input logic            rst_n,
    qnigma_dns_rx_if.slave bus
);
    localparam int AW = $clog2(MAX_ANS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0, HDR   = 3'd1, QNAME = 3'd2, QINFO = 3'd3,
        ANAME = 3'd4, AINFO = 3'd5, RDATA = 3'd6, DRAIN = 3'd7
    } state_t;

    state_t         state_r;
    logic [15:0]    cnt_r, name_cnt_r, rdlen_r, tid_tmp_r, qd_r, an_r, type_r, class_r;
    logic           qr_r, ptr_r, bad_r, found_r, match_r;
    logic [3:0]     rc_tmp_r;
    logic [5:0]     lbl_r;
    logic [AW-1:0]  ans_cnt_r;
    logic [127:0]   addr_tmp_r;
    logic           val_r, err_r, busy_r;
    logic [127:0]   addr_r;
    logic [15:0]    tid_r;
    logic [3:0]     rcode_r;

    logic           name_over_s, name_end_s, name_bad_s, hdr_ok_s, hdr_cmp_s;
    logic           rd_last_s, rec_end_s, rec_found_s, ans_last_s, good_s;
    logic [15:0]    rdlen_full_s, ans_lim_s;
    logic [127:0]   addr_nxt_s;

    assign bus.val   = val_r;
    assign bus.err   = err_r;
    assign bus.addr  = addr_r;
    assign bus.tid   = tid_r;
    assign bus.rcode = rcode_r;
    assign bus.busy  = busy_r;

    // Per-byte decisions: name label walking, header verdict, record end, final verdict.
    always_comb begin
        name_over_s = (name_cnt_r >= 16'(MAX_NAME));
        if (ptr_r || (lbl_r != 6'd0)) begin
            name_end_s = ptr_r && !name_over_s;
            name_bad_s = name_over_s;
        end else begin
            name_end_s = !name_over_s && (bus.dat == 8'h00);
            name_bad_s = name_over_s || (bus.dat[7:6] == 2'b01) || (bus.dat[7:6] == 2'b10);
        end
        hdr_ok_s     = (tid_tmp_r == EXP_TID) && qr_r && (rc_tmp_r == 4'd0) &&
                       (qd_r == 16'd1) && (an_r != 16'd0);
        hdr_cmp_s    = (state_r != HDR) || (cnt_r == 16'd11);
        rdlen_full_s = {rdlen_r[15:8], bus.dat};
        rd_last_s    = (cnt_r == (rdlen_r - 16'd1));
        rec_end_s    = ((state_r == AINFO) && (cnt_r == 16'd9) && (rdlen_full_s == 16'd0)) ||
                       ((state_r == RDATA) && rd_last_s);
        rec_found_s  = (state_r == RDATA) && match_r;
        ans_lim_s    = (an_r > 16'(MAX_ANS)) ? 16'(MAX_ANS) : an_r;
        ans_last_s   = ((16'(ans_cnt_r) + 16'd1) >= ans_lim_s);
        // A frame may end on the very byte that completes the matching record.
        good_s       = ((state_r == DRAIN) && found_r && !bad_r) || (rec_found_s && rd_last_s);
        addr_nxt_s   = (state_r == RDATA) ? {addr_tmp_r[119:0], bus.dat} : addr_tmp_r;
    end

    // Parser FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 16'd0;
            name_cnt_r <= 16'd0;
            rdlen_r    <= 16'd0;
            tid_tmp_r  <= 16'd0;
            qd_r       <= 16'd0;
            an_r       <= 16'd0;
            type_r     <= 16'd0;
            class_r    <= 16'd0;
            qr_r       <= 1'b0;
            ptr_r      <= 1'b0;
            bad_r      <= 1'b0;
            found_r    <= 1'b0;
            match_r    <= 1'b0;
            rc_tmp_r   <= 4'd0;
            lbl_r      <= 6'd0;
            ans_cnt_r  <= '0;
            addr_tmp_r <= 128'd0;
            val_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            addr_r     <= 128'd0;
            tid_r      <= 16'd0;
            rcode_r    <= 4'd0;
        end else begin
            val_r <= 1'b0;
            err_r <= 1'b0;
            if (bus.vld && bus.sof) begin
                state_r   <= HDR;
                cnt_r     <= 16'd1;
                tid_tmp_r <= {bus.dat, 8'h00};
                bad_r     <= 1'b0;
                found_r   <= 1'b0;
                match_r   <= 1'b0;
                ans_cnt_r <= '0;
                if (bus.eof) begin
                    state_r <= IDLE;
                    err_r   <= 1'b1;
                    busy_r  <= 1'b0;
                end else begin
                    busy_r  <= 1'b1;
                end
            end else if (bus.vld && (state_r != IDLE)) begin
                cnt_r <= cnt_r + 16'd1;
                case (state_r)
                    HDR: begin
                        case (cnt_r)
                            16'd1:   tid_tmp_r[7:0] <= bus.dat;
                            16'd2:   qr_r           <= bus.dat[7];
                            16'd3:   rc_tmp_r       <= bus.dat[3:0];
                            16'd4:   qd_r[15:8]     <= bus.dat;
                            16'd5:   qd_r[7:0]      <= bus.dat;
                            16'd6:   an_r[15:8]     <= bus.dat;
                            16'd7:   an_r[7:0]      <= bus.dat;
                            default: begin end
                        endcase
                        if (cnt_r == 16'd11) begin
                            cnt_r      <= 16'd0;
                            name_cnt_r <= 16'd0;
                            lbl_r      <= 6'd0;
                            ptr_r      <= 1'b0;
                            state_r    <= hdr_ok_s ? QNAME : DRAIN;
                            bad_r      <= !hdr_ok_s;
                        end
                    end
                    QNAME, ANAME: begin
                        name_cnt_r <= name_cnt_r + 16'd1;
                        if (name_bad_s) begin
                            state_r <= DRAIN;
                            bad_r   <= 1'b1;
                        end else if (name_end_s) begin
                            state_r <= (state_r == QNAME) ? QINFO : AINFO;
                            cnt_r   <= 16'd0;
                        end else if (lbl_r != 6'd0) begin
                            lbl_r <= lbl_r - 6'd1;
                        end else if (bus.dat[7:6] == 2'b11) begin
                            ptr_r <= 1'b1;
                        end else begin
                            lbl_r <= bus.dat[5:0];
                        end
                    end
                    QINFO: begin
                        if (cnt_r == 16'd3) begin
                            state_r    <= ANAME;
                            cnt_r      <= 16'd0;
                            name_cnt_r <= 16'd0;
                            lbl_r      <= 6'd0;
                            ptr_r      <= 1'b0;
                        end
                    end
                    AINFO: begin
                        case (cnt_r)
                            16'd0:   type_r[15:8]  <= bus.dat;
                            16'd1:   type_r[7:0]   <= bus.dat;
                            16'd2:   class_r[15:8] <= bus.dat;
                            16'd3:   class_r[7:0]  <= bus.dat;
                            16'd8:   rdlen_r[15:8] <= bus.dat;
                            default: begin end
                        endcase
                        if (cnt_r == 16'd9) begin
                            rdlen_r <= rdlen_full_s;
                            match_r <= (type_r == 16'd28) && (class_r == 16'd1) &&
                                       (rdlen_full_s == 16'd16);
                            state_r <= RDATA;
                            cnt_r   <= 16'd0;
                        end
                    end
                    RDATA: begin
                        if (match_r) begin
                            addr_tmp_r <= {addr_tmp_r[119:0], bus.dat};
                        end
                    end
                    DRAIN:   begin end
                    default: state_r <= IDLE;
                endcase
                // Record end overrides the per-state transition above.
                if (rec_end_s) begin
                    ans_cnt_r <= ans_cnt_r + {{(AW-1){1'b0}}, 1'b1};
                    cnt_r     <= 16'd0;
                    if (rec_found_s) begin
                        found_r <= 1'b1;
                        state_r <= DRAIN;
                    end else if (ans_last_s) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r    <= ANAME;
                        name_cnt_r <= 16'd0;
                        lbl_r      <= 6'd0;
                        ptr_r      <= 1'b0;
                    end
                end
                if (bus.eof) begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    if (good_s) begin
                        val_r  <= 1'b1;
                        addr_r <= addr_nxt_s;
                    end else begin
                        err_r  <= 1'b1;
                    end
                    if (hdr_cmp_s) begin
                        tid_r   <= tid_tmp_r;
                        rcode_r <= rc_tmp_r;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_qnigma_dns_rx.sv
// Scoreboard bench for qnigma_dns_rx: frames are parsed by a byte-level reference model,
// expected results are queued and a monitor checks every val/err pulse against them.
module tb_qnigma_dns_rx;
    localparam logic [15:0] EXP_TID  = 16'd12345;
    localparam int          MAX_NAME = 255;
    localparam int          MAX_ANS  = 8;
    localparam logic [127:0] A1 = 128'h20010db8000000000000000000000001;
    localparam logic [127:0] A2 = 128'hfe800000000000000000000000000002;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    qnigma_dns_rx_if bus();
    qnigma_dns_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit           is_val;
        logic [127:0] addr;
        logic [15:0]  tid;
        logic [3:0]   rcode;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    logic [7:0]   f[$];
    logic [127:0] m_addr = 128'd0;
    logic [15:0]  m_tid = 16'd0;
    logic [3:0]   m_rcode = 4'd0;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           gap_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (bus.val === 1'b1 || bus.err === 1'b1)) begin
            chk("val_err_exclusive", 128'(bus.val & bus.err), 128'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual val=%0b err=%0b required none", bus.val, bus.err);
            end else begin
                e = sb.pop_front();
                chk("result_is_val", 128'(bus.val), 128'(e.is_val));
                chk("latency_cycle", 128'(cyc), 128'(e.cyc));
                chk("addr", bus.addr, e.addr);
                chk("tid", 128'(bus.tid), 128'(e.tid));
                chk("rcode", 128'(bus.rcode), 128'(e.rcode));
                chk("busy_at_pulse", 128'(bus.busy), 128'd0);
            end
        end
    end

    // Reference model: walk the byte list by offsets as the DNS wire format defines it.
    function automatic int skip_name(input int p0, input int n);
        int p = p0;
        int cnt = 0;
        logic [7:0] b;
        while (1'b1) begin
            if (p >= n) return -1;
            b = f[p];
            p++;
            cnt++;
            if (cnt > MAX_NAME) return -1;
            if (b == 8'h00) return p;
            if (b[7:6] == 2'b11) begin
                if (p >= n || cnt + 1 > MAX_NAME) return -1;
                return p + 1;
            end
            if (b[7:6] != 2'b00) return -1;
            p += int'(b[5:0]);
            cnt += int'(b[5:0]);
            if (cnt > MAX_NAME) return -1;
        end
        return -1;
    endfunction

    task automatic model_eval(output bit ok);
        int n, p, lim, rdl;
        logic [15:0] an, typ, cls;
        logic [127:0] a;
        ok = 1'b0;
        n = f.size();
        if (n < 12) return;
        m_tid = {f[0], f[1]};
        m_rcode = f[3][3:0];
        if ({f[0], f[1]} != EXP_TID || f[2][7] != 1'b1 || f[3][3:0] != 4'd0 || {f[4], f[5]} != 16'd1) return;
        an = {f[6], f[7]};
        if (an == 16'd0) return;
        p = skip_name(12, n);
        if (p < 0 || p + 4 > n) return;
        p += 4;
        lim = (int'(an) > MAX_ANS) ? MAX_ANS : int'(an);
        for (int k = 0; k < lim; k++) begin
            p = skip_name(p, n);
            if (p < 0 || p + 10 > n) return;
            typ = {f[p], f[p+1]};
            cls = {f[p+2], f[p+3]};
            rdl = int'({f[p+8], f[p+9]});
            p += 10;
            if (p + rdl > n) return;
            if (typ == 16'd28 && cls == 16'd1 && rdl == 16) begin
                for (int j = 0; j < 16; j++) a[127-8*j -: 8] = f[p+j];
                m_addr = a;
                ok = 1'b1;
                return;
            end
            p += rdl;
        end
    endtask

    task automatic b8(input logic [7:0] x);
        f.push_back(x);
    endtask

    task automatic b16(input logic [15:0] x);
        f.push_back(x[15:8]);
        f.push_back(x[7:0]);
    endtask

    task automatic hdr(input logic [15:0] tid, input logic [15:0] flg, input logic [15:0] qd, input logic [15:0] an);
        f.delete();
        b16(tid); b16(flg); b16(qd); b16(an); b16(16'd0); b16(16'd0);
    endtask

    task automatic put_label(input string s);
        b8(8'(s.len()));
        for (int i = 0; i < s.len(); i++) b8(8'(s[i]));
    endtask

    task automatic std_q();
        put_label("qnigma"); put_label("io"); b8(8'h00);
        b16(16'd28); b16(16'd1);
    endtask

    task automatic rr(input bit lbl_name, input logic [15:0] typ, input logic [15:0] cls,
                      input int rdlen, input logic [127:0] a);
        if (lbl_name) begin put_label("ns"); b8(8'h00); end
        else b16(16'hC00C);
        b16(typ); b16(cls); b16(16'd0); b16(16'd300); b16(16'(rdlen));
        for (int i = 0; i < rdlen; i++) b8((i < 16) ? a[127-8*i -: 8] : 8'($urandom));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_byte(input logic [7:0] b, input bit s, input bit e);
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            @(negedge clk);
            bus.vld = 1'b0; bus.sof = 1'($urandom); bus.eof = 1'($urandom); bus.dat = 8'($urandom);
        end
        @(negedge clk);
        bus.dat = b; bus.vld = 1'b1; bus.sof = s; bus.eof = e;
    endtask

    task automatic send_prefix(input int k);
        for (int i = 0; i < k; i++) drive_byte(f[i], i == 0, 1'b0);
    endtask

    task automatic send_full();
        exp_t e;
        bit ok;
        int n = f.size();
        for (int i = 0; i < n; i++) begin
            drive_byte(f[i], i == 0, i == n - 1);
            if (i == n - 1) begin
                model_eval(ok);
                e.is_val = ok; e.addr = m_addr; e.tid = m_tid; e.rcode = m_rcode; e.cyc = cyc + 1;
                sb.push_back(e);
            end
            if (i == 1 && n > 2) chk("busy_mid_frame", 128'(bus.busy), 128'd1);
        end
        @(negedge clk);
        bus.vld = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
    endtask

    task automatic gen_random();
        logic [15:0] flg, an;
        int r, k, len;
        flg = 16'h8180;
        r = $urandom_range(0, 15);
        if (r == 0) flg = 16'h8183;
        if (r == 1) flg = 16'h0180;
        an = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 10));
        hdr(($urandom_range(0, 7) == 0) ? 16'd12346 : EXP_TID, flg,
            ($urandom_range(0, 11) == 0) ? 16'd2 : 16'd1, an);
        r = $urandom_range(0, 11);
        if (r == 0) begin
            b8($urandom_range(0, 1) ? 8'h80 : 8'h40); b8(8'h01); b8(8'h00); b16(16'd28); b16(16'd1);
        end else if (r == 1) begin
            k = $urandom_range(3, 5);
            for (int i = 0; i < k; i++) begin
                len = $urandom_range(50, 63);
                b8(8'(len));
                for (int j = 0; j < len; j++) b8(8'($urandom));
            end
            b8(8'h00); b16(16'd28); b16(16'd1);
        end else begin
            std_q();
        end
        for (int i = 0; i < int'(an); i++) begin
            case ($urandom_range(0, 5))
                0, 5: rr(1'($urandom), 16'd28, 16'd1, 16, rnd128());
                1:    rr(1'($urandom), 16'd1, 16'd1, 4, rnd128());
                2:    rr(1'($urandom), 16'd5, 16'd1,
                         ($urandom_range(0, 3) == 0) ? $urandom_range(200, 300) : $urandom_range(0, 20), rnd128());
                3:    rr(1'b0, 16'd28, 16'd3, 16, rnd128());
                default: rr(1'b0, 16'd28, 16'd1, 4, rnd128());
            endcase
        end
        repeat ($urandom_range(0, 3)) b8(8'($urandom));
        if ($urandom_range(0, 5) == 0) begin
            len = $urandom_range(1, f.size());
            while (f.size() > len) void'(f.pop_back());
        end
    endtask

    task automatic directed();
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd28, 16'd1, 16, A1);
        send_full();
        chk("tp_valid_addr", bus.addr, A1);
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd2); std_q();
        rr(1'b0, 16'd5, 16'd1, 9, rnd128()); rr(1'b0, 16'd28, 16'd1, 16, A2);
        send_full();
        chk("tp_cname_then_aaaa", bus.addr, A2);
        hdr(16'd12346, 16'h8180, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd28, 16'd1, 16, A1);
        send_full();
        chk("tp_bad_tid_addr_kept", bus.addr, A2);
        hdr(EXP_TID, 16'h8183, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd28, 16'd1, 16, A1);
        send_full();
        chk("tp_nxdomain_rcode", 128'(bus.rcode), 128'd3);
        chk("tp_nxdomain_addr_kept", bus.addr, A2);
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd28, 16'd1, 16, A1);
        repeat (8) void'(f.pop_back());
        send_full();
        chk("tp_truncated_addr_kept", bus.addr, A2);
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd28, 16'd1, 16, A2);
        send_prefix(16);
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd28, 16'd1, 16, A1);
        send_full();
        chk("tp_restart_addr", bus.addr, A1);
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd1, 16'd1, 4, A2);
        send_full();
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd1); b8(8'h80); b8(8'h01); b8(8'h00);
        b16(16'd28); b16(16'd1); rr(1'b0, 16'd28, 16'd1, 16, A2);
        send_full();
        chk("tp_bad_label_addr_kept", bus.addr, A1);
        f.delete(); b8(8'h30);
        send_full();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.dat = 8'h00; bus.vld = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_val", 128'(bus.val), 128'd0);
        chk("reset_err", 128'(bus.err), 128'd0);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_addr", bus.addr, 128'd0);
        chk("reset_tid", 128'(bus.tid), 128'd0);
        chk("reset_rcode", 128'(bus.rcode), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        gap_mode = 0;
        directed();
        gap_mode = 1;
        directed();

        for (int it = 0; it < 150; it++) begin
            gap_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) begin
                gen_random();
                if (f.size() > 1) send_prefix($urandom_range(1, f.size() - 1));
            end
            gen_random();
            send_full();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        gap_mode = 0;
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd28, 16'd1, 16, A2);
        send_prefix(30);
        @(negedge clk);
        rst_n = 1'b0; bus.vld = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_addr = 128'd0; m_tid = 16'd0; m_rcode = 4'd0;
        chk("midreset_busy", 128'(bus.busy), 128'd0);
        chk("midreset_addr", bus.addr, 128'd0);
        chk("midreset_tid", 128'(bus.tid), 128'd0);
        hdr(EXP_TID, 16'h8180, 16'd1, 16'd1); std_q(); rr(1'b0, 16'd28, 16'd1, 16, A2);
        send_full();
        chk("post_reset_addr", bus.addr, A2);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
